div_seq: RTL and testbench



---
 rtl/div_pkg.sv | 32 +++
 rtl/alu.sv | 56 +++++
 rtl/div_seq.sv | 130 +++++++++++++
 tb/tb_div_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types and constants for the RV32M divide sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        FIXUP  = 2'b10,
        DONE   = 2'b11
    } div_state_t;

    localparam logic [3:0] ALU_SUB = 4'b0001;

    // DIV and REM are the signed flavours (op[0] clear).
    function automatic logic op_is_signed(input div_op_t op);
        return ~op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// alu : shared integer ALU; subtract reports carry-out as "no borrow".
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] result,
    output logic            carry_out,
    output logic            zero,
    output logic            less_than
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    logic            sub;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   add_full;

    assign sub      = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
    assign b_eff    = sub ? ~b : b;
    assign add_full = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};

    assign carry_out = add_full[XLEN];
    // Signed compare: differing signs decide directly, otherwise the difference sign.
    assign less_than = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : add_full[XLEN-1];

    always_comb begin
        result = add_full[XLEN-1:0];
        case (alu_control)
            ALU_ADD: result = add_full[XLEN-1:0];
            ALU_SUB: result = add_full[XLEN-1:0];
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, less_than};
            default: result = add_full[XLEN-1:0];
        endcase
    end

    assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// div_seq : multi-cycle RV32M DIV/DIVU/REM/REMU using restoring division.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_seq
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state, state_next;
    div_op_t         op_in, op_q;
    logic [XLEN-1:0] q, d, r, result_q;
    logic [CNT_W-1:0] cnt;
    logic            negq, negr;

    logic            sgn_in, b_zero, ovf, accept_start;
    logic [XLEN-1:0] r_shift, alu_sum;
    logic            alu_cout, accept;
    logic            alu_zero_unused, alu_lt_unused;

    assign op_in        = div_op_t'(op);
    assign sgn_in       = op_is_signed(op_in);
    assign b_zero       = (b == '0);
    assign ovf          = sgn_in && (a == MIN_NEG) && (b == '1);
    assign accept_start = start && !kill;

    assign r_shift = {r[XLEN-2:0], q[XLEN-1]};

    alu #(.XLEN(XLEN)) u_alu (
        .a           (r_shift),
        .b           (d),
        .alu_control (ALU_SUB),
        .result      (alu_sum),
        .carry_out   (alu_cout),
        .zero        (alu_zero_unused),
        .less_than   (alu_lt_unused)
    );

    // The shifted remainder is XLEN+1 bits wide; its top bit is R[XLEN-1].
    assign accept = r[XLEN-1] | alu_cout;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept_start) state_next = (b_zero || ovf) ? DONE : DIVIDE;
            DIVIDE: if (kill) state_next = IDLE;
                    else if (cnt == CNT_LAST) state_next = FIXUP;
            FIXUP:  state_next = kill ? IDLE : DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            d        <= '0;
            r        <= '0;
            cnt      <= '0;
            negq     <= 1'b0;
            negr     <= 1'b0;
            op_q     <= DIV;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        if (b_zero) begin
                            result_q <= (op_in == DIV || op_in == DIVU) ? '1 : a;
                        end else if (ovf) begin
                            result_q <= (op_in == DIV) ? MIN_NEG : '0;
                        end else begin
                            q    <= (sgn_in && a[XLEN-1]) ? -a : a;
                            d    <= (sgn_in && b[XLEN-1]) ? -b : b;
                            r    <= '0;
                            cnt  <= '0;
                            negq <= sgn_in && (a[XLEN-1] ^ b[XLEN-1]);
                            negr <= sgn_in && a[XLEN-1];
                            op_q <= op_in;
                        end
                    end
                end
                DIVIDE: begin
                    if (!kill) begin
                        r   <= accept ? alu_sum : r_shift;
                        q   <= {q[XLEN-2:0], accept};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIXUP: begin
                    if (!kill) begin
                        if (op_q == DIV || op_q == DIVU) result_q <= negq ? -q : q;
                        else                             result_q <= negr ? -r : r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// tb_div_seq : directed self-checking bench for div_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_seq;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int INJ_NONE  = 0;
    localparam int INJ_START = 1;
    localparam int INJ_KILL  = 2;
    localparam int INJ_RESET = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_fail = 0;

    div_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic clear_inj();
        start = 1'b0;
        kill  = 1'b0;
        reset = 1'b0;
        a     = '0;
        b     = '0;
    endtask

    // Issues one op from IDLE, optionally injects a one-cycle event at cycle
    // inj_at, and stops at the done cycle (lat) or after 60 cycles (lat=-1).
    // Returns one cycle after done, so the next call starts right after done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          input int inj_at, input int inj_kind,
                          output logic [31:0] res, output int lat, output int busy_bad,
                          output logic busy_inj, output logic busy_post);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        clear_inj();
        lat = 1; busy_bad = 0; busy_inj = 1'bx;
        for (int guard = 0; guard < 100; guard++) begin
            if (lat == inj_at + 1) busy_inj = busy;
            if (inj_kind < INJ_KILL && !busy) busy_bad++;
            if (lat == inj_at) begin
                case (inj_kind)
                    INJ_START: begin start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3; end
                    INJ_KILL:  kill = 1'b1;
                    INJ_RESET: reset = 1'b1;
                    default: ;
                endcase
            end
            if (done) break;
            if (lat >= 60) begin lat = -1; break; end
            @(posedge clk); #1;
            clear_inj();
            lat++;
        end
        res = result;
        @(posedge clk); #1;
        clear_inj();
        busy_post = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=00000000", result); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] res; int lat, bb_cnt; logic bi, bp;
        run_op(OP_DIV, 32'd100, 32'd7, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL div_100_7 got=%h exp=%h", res, 32'd14); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency got=%0d exp=34", lat); end
        n_cmp++; if (bb_cnt !== 0) begin n_fail++; $display("FAIL div_busy_low_cycles got=%0d exp=0", bb_cnt); end
        n_cmp++; if (bp !== 1'b0) begin n_fail++; $display("FAIL div_busy_after_done got=%b exp=0", bp); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got=%b exp=0", done); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL result_hold got=%h exp=%h", result, 32'd14); end
        run_op(OP_REM, 32'd100, 32'd7, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'd2) begin n_fail++; $display("FAIL rem_100_7 got=%h exp=%h", res, 32'd2); end
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL rem_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_signed();
        logic [1:0]  t_op [8] = '{OP_DIV, OP_REM, OP_REMU, OP_DIVU, OP_DIV, OP_REM, OP_REM, OP_DIVU};
        logic [31:0] t_a  [8] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF};
        logic [31:0] t_b  [8] = '{32'd7, 32'd7, 32'h80000001, 32'h80000001,
                                  32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
        logic [31:0] t_e  [8] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'h7FFFFFFE, 32'd1,
                                  32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] res; int lat, bb_cnt; logic bi, bp;
        for (int i = 0; i < 8; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
            n_cmp++;
            if (res !== t_e[i] || lat !== 34) begin
                n_fail++;
                $display("FAIL signed_vec%0d got=%h lat=%0d exp=%h lat=34", i, res, lat, t_e[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] res; int lat, bb_cnt; logic bi, bp;
        // A start held high during the DONE cycle must be ignored.
        run_op(OP_DIVU, 32'd5, 32'd0, 1, INJ_START, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_by0 got=%h exp=ffffffff", res); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL divu_by0_latency got=%0d exp=1", lat); end
        n_cmp++; if (bp !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ignored busy=%b exp=0", bp); end
        run_op(OP_REM, 32'hFFFFFFFB, 32'd0, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL rem_by0 got=%h exp=fffffffb", res); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rem_by0_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_overflow();
        logic [31:0] res; int lat, bb_cnt; logic bi, bp;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'h80000000 || lat !== 1) begin n_fail++; $display("FAIL div_ovf got=%h lat=%0d exp=80000000 lat=1", res, lat); end
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL rem_ovf got=%h lat=%0d exp=00000000 lat=1", res, lat); end
        run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'h0 || lat !== 34) begin n_fail++; $display("FAIL divu_no_ovf got=%h lat=%0d exp=00000000 lat=34", res, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat, bb_cnt; logic bi, bp;
        run_op(OP_DIV, 32'd100, 32'd7, 10, INJ_START, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'd14 || lat !== 34) begin n_fail++; $display("FAIL start_while_busy got=%h lat=%0d exp=0000000e lat=34", res, lat); end
        run_op(OP_DIV, 32'd9, 32'd3, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'd3 || lat !== 34) begin n_fail++; $display("FAIL start_after_done got=%h lat=%0d exp=00000003 lat=34", res, lat); end
    endtask

    task automatic test_kill();
        logic [31:0] res; int lat, bb_cnt; logic bi, bp;
        run_op(OP_DIV, 32'd100, 32'd7, 20, INJ_KILL, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (bi !== 1'b0) begin n_fail++; $display("FAIL kill_busy got=%b exp=0", bi); end
        n_cmp++; if (lat !== -1) begin n_fail++; $display("FAIL kill_no_done got=%0d exp=-1", lat); end
        n_cmp++; if (res !== 32'd3) begin n_fail++; $display("FAIL kill_result_kept got=%h exp=00000003", res); end
        // kill alongside start in IDLE: nothing may start.
        op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        clear_inj();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_with_start got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; int lat, bb_cnt; logic bi, bp;
        run_op(OP_DIV, 32'd100, 32'd7, 15, INJ_RESET, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (bi !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%b exp=0", bi); end
        n_cmp++; if (lat !== -1) begin n_fail++; $display("FAIL reset_mid_no_done got=%0d exp=-1", lat); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result got=%h exp=00000000", res); end
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, -5, INJ_NONE, res, lat, bb_cnt, bi, bp);
        n_cmp++; if (res !== 32'hFFFFFFFD || lat !== 34) begin n_fail++; $display("FAIL after_reset_div got=%h lat=%0d exp=fffffffd lat=34", res, lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
